disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Scan controller for a multiplexed NUM_DIGITS-digit 7-segment display.
- Time-shares one external combinational bin-to-7-seg decoder across all digits.
- Takes a packed hex value through a valid/ready handshake and applies it only at frame boundaries, so the display never tears.
- Sits between the 4-bit counters/datapath and the display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; digit 0 is the least-significant nibble (rightmost).
PRESCALE, 4, clk cycles each digit is lit; must be >= 1.
BLANK_CYCLES, 1, guard cycles with all digits off before each digit, for anti-ghosting and decoder settling; must be >= 1.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  synchronous active-low reset (sampled on rising clk).
en  input  1  scan enable; low freezes the scan and darkens the display.
lzb  input  1  leading-zero blanking enable.
value_in  input  4*NUM_DIGITS  packed hex digits; nibble i goes to digit i.
value_valid  input  1  value_in is offered.
value_ready  output  1  controller can accept a value.
nibble  output  4  registered nibble driven to the shared decoder.
seg_in  input  7  decoder result (a..g MSB-first, 1 = segment on).
seg_out  output  7  gated segments to the display.
dig_en  output  NUM_DIGITS  registered one-hot digit enable, active-high.
frame_done  output  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Outputs: dig_en=0, seg_out=0, nibble=0, frame_done=0, value_ready=1.
  - Internal: active register=0, pending buffer empty, state=S_BLANK, digit idx=0, slot counter=0.
  - Reset mid-frame discards both the pending and the active value.
- FSM has two states.
  - S_BLANK: lasts BLANK_CYCLES cycles. dig_en=0. nibble=active[idx*4 +: 4].
  - S_SHOW: lasts PRESCALE cycles. dig_en=1<<idx, unless the digit is blanked. nibble holds.
  - Last S_SHOW cycle: idx <= (idx+1) mod NUM_DIGITS; state returns to S_BLANK.
- nibble leads dig_en by BLANK_CYCLES cycles. The decoder path is combinational, so seg_in is valid before the digit lights.
- seg_out = seg_in when in S_SHOW, en=1 and the digit is not blanked; otherwise 7'b0000000.
- Frame length is NUM_DIGITS*(BLANK_CYCLES+PRESCALE) cycles (20 with defaults).
- Frame end is the last S_SHOW cycle of digit NUM_DIGITS-1. At that edge:
  - frame_done registers high for exactly one cycle, the first S_BLANK cycle of the next frame.
  - If pending is full: active <= pending, pending empties.
- Handshake:
  - value_ready = !pending_full.
  - Transfer occurs when value_valid && value_ready; value_in is captured into pending.
  - value_ready is low from the cycle after the transfer until the cycle after the frame-end copy.
  - Transfer in the same cycle as frame end with pending empty: the value goes to pending, not active. It displays one frame later.
  - value_valid while ready=0: nothing is captured; the source must hold.
- Leading-zero blanking (lzb=1):
  - Digit i>0 is blanked when all nibbles i..NUM_DIGITS-1 of active are zero.
  - Digit 0 is never blanked, so value 0 shows "0".
  - A blanked digit keeps its full slot timing with dig_en=0 and seg_out=0.
  - lzb is evaluated combinationally against the active register.
- en=0:
  - State, idx and slot counter hold.
  - dig_en and seg_out are forced to 0; frame_done cannot pulse.
  - The handshake and pending capture keep working.
  - When en returns to 1, the scan resumes with the remaining slot cycles.
- Counters wrap only via the explicit idx and slot rules above; there is no free-running overflow.

Decomposition:
- Shared package holds:
  - state encodings S_BLANK/S_SHOW;
  - SEG_OFF = 7'b0000000;
  - helper constant for the frame length.
- One natural sub-module: lzb_mask, a combinational function of the active register and lzb returning a NUM_DIGITS-bit blank mask.
- The decoder stays external and shared; it is not instantiated inside this block.

Test Plan (defaults, 20-cycle frame):
- Reset low 3 cycles, then released: all outputs 0 and ready=1 during reset. After release, dig_en runs 0000 (1 cycle), 0001 x4, 0000, 0010 x4, 0000, 0100 x4, 0000, 1000 x4. frame_done=1 at cycle 21.
- value 16'h12AF offered at cycle 7: ready=0 from cycle 8 and the display stays "0000" this frame. Next frame nibble = F,A,2,1 on digits 0..3, and seg_out during digit 0 = seg_in (decoder 1000111). ready returns to 1 after the copy.
- Second value 16'h3333 offered while pending is full: not captured, ready=0. It is captured the cycle after frame end and displays one frame later.
- lzb=1, value 16'h0005: digits 1..3 never assert dig_en; digit 0 shows seg_out=1011011. Value 16'h0000: only digit 0 lights, seg_out=1111110.
- reset_n low for one edge during S_SHOW of digit 2 with pending full: next cycle dig_en=0, seg_out=0, ready=1. Following frames show "0000".
- en low for 7 cycles starting at the 2nd S_SHOW cycle of digit 1: dig_en=0 and seg_out=0 throughout, with no frame_done. Afterwards digit 1 stays lit 3 more cycles, then the scan proceeds normally.

Source files
------------

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package disp_scan_ctrl_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    function automatic int unsigned frame_cycles(input int unsigned num_digits,
                                                 input int unsigned blank_cycles,
                                                 input int unsigned prescale);
        return num_digits * (blank_cycles + prescale);
    endfunction

    localparam int unsigned FRAME_LEN_DEFAULT = frame_cycles(4, 1, 4);

endpackage

// File: rtl/disp_scan_ctrl_lzb_mask.sv
// Leading-zero blanking mask: bit i set when digit i and every digit above it are zero.
module disp_scan_ctrl_lzb_mask
    import disp_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] active,
    input  logic                    lzb,
    output logic [NUM_DIGITS-1:0]   mask
);

    logic upper_zero;

    // Digit 0 is never blanked so a zero value still shows "0".
    always_comb begin
        mask       = '0;
        upper_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (active[4*i +: 4] == 4'h0);
            mask[i]    = lzb & upper_zero;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller; new values are latched into a pending
// buffer and only promoted to the displayed value at a frame boundary.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    lzb,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [3:0]              nibble,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int unsigned SlotMax = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned SlotW   = $clog2(SlotMax + 1);
    localparam int unsigned IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ValW    = 4 * NUM_DIGITS;

    localparam logic [SlotW-1:0] ShowLast  = SlotW'(PRESCALE - 1);
    localparam logic [SlotW-1:0] BlankLast = SlotW'(BLANK_CYCLES - 1);
    localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_DIGITS - 1);

    state_t                state_q, state_d;
    logic [SlotW-1:0]      slot_q, slot_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [ValW-1:0]       active_q, active_d, pending_q;
    logic                  pending_full_q;
    logic [3:0]            nibble_q;
    logic                  frame_done_q;
    logic                  frame_end, xfer, show_on;
    logic [NUM_DIGITS-1:0] blank_mask;

    disp_scan_ctrl_lzb_mask #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_lzb_mask (
        .active(active_q),
        .lzb   (lzb),
        .mask  (blank_mask)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_BLANK;
            slot_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
        end
    end

    // en=0 freezes the scan exactly where it is; the slot resumes on re-enable.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        idx_d     = idx_q;
        frame_end = 1'b0;
        if (en) begin
            unique case (state_q)
                S_BLANK: begin
                    if (slot_q == BlankLast) begin
                        state_d = S_SHOW;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (slot_q == ShowLast) begin
                        state_d   = S_BLANK;
                        slot_d    = '0;
                        idx_d     = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                        frame_end = (idx_q == IdxLast);
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                default: state_d = S_BLANK;
            endcase
        end
    end

    assign xfer     = value_valid & ~pending_full_q;
    assign active_d = (frame_end && pending_full_q) ? pending_q : active_q;

    // A capture coinciding with frame end lands in pending, not active.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            nibble_q       <= 4'h0;
            frame_done_q   <= 1'b0;
        end else begin
            active_q     <= active_d;
            nibble_q     <= active_d[{idx_d, 2'b00} +: 4];
            frame_done_q <= frame_end;
            if (frame_end && pending_full_q) begin
                pending_full_q <= 1'b0;
            end else if (xfer) begin
                pending_q      <= value_in;
                pending_full_q <= 1'b1;
            end
        end
    end

    always_comb begin
        show_on     = en && (state_q == S_SHOW) && !blank_mask[idx_q];
        dig_en      = show_on ? (NUM_DIGITS'(1) << idx_q) : '0;
        seg_out     = show_on ? seg_in : SEG_OFF;
        nibble      = nibble_q;
        frame_done  = frame_done_q;
        value_ready = ~pending_full_q;
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: per-cycle expected scan outputs are queued by
// each scenario and checked by a monitor; handshake ready is checked inline.
module tb_disp_scan_ctrl;
    import disp_scan_ctrl_pkg::*;

    localparam int ND    = 4;
    localparam int PS    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = BC + PS;
    localparam int FRAME = int'(frame_cycles(ND, BC, PS));

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic [3:0] nib;
        logic       fd;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b1;
    logic          lzb = 1'b0;
    logic [15:0]   value_in = '0;
    logic          value_valid = 1'b0;
    logic          value_ready;
    logic [3:0]    nibble;
    logic [6:0]    seg_in;
    logic [6:0]    seg_out;
    logic [ND-1:0] dig_en;
    logic          frame_done;

    logic          drv_rst_n = 1'b1;
    logic          drv_en = 1'b1;
    logic          drv_lzb = 1'b0;
    logic          drv_valid = 1'b0;
    logic [15:0]   drv_value = '0;
    logic          mon_on = 1'b0;
    logic          exp_rdy;

    obs_t sb_q[$];
    obs_t exp_o, got_o;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // External shared decoder.
    assign seg_in = seg_lut(nibble);

    disp_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .PRESCALE    (PS),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .lzb        (lzb),
        .value_in   (value_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .nibble     (nibble),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    // Expected outputs at cycle c of a frame displaying v (c = 0 is the first blank cycle).
    function automatic obs_t model(input logic [15:0] v, input logic l, input int c,
                                   input logic fd);
        obs_t o;
        int   d;
        int   s;
        logic blk;
        d     = c / SLOT;
        s     = c % SLOT;
        blk   = l && (d > 0) && ((v >> (4 * d)) == 16'h0);
        o.nib = v[d*4 +: 4];
        o.fd  = (c == 0) ? fd : 1'b0;
        if (s < BC || blk) begin
            o.dig = '0;
            o.seg = '0;
        end else begin
            o.dig = 4'b0001 << d;
            o.seg = seg_lut(o.nib);
        end
        return o;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic l, input logic fd,
                              input int c0, input int c1);
        for (int c = c0; c <= c1; c++) sb_q.push_back(model(v, l, c, fd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        reset_n     = drv_rst_n;
        en          = drv_en;
        lzb         = drv_lzb;
        value_valid = drv_valid;
        value_in    = drv_value;
        mon_on      = 1'b1;
        #1;
    endtask

    always begin
        @(posedge clk);
        #2;
        if (mon_on) begin
            vectors++;
            got_o = '{dig: dig_en, seg: seg_out, nib: nibble, fd: frame_done};
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL scan_underflow @%0t: got dig=%b seg=%b, want none queued",
                         $time, dig_en, seg_out);
            end else begin
                exp_o = sb_q.pop_front();
                if (got_o !== exp_o)
                begin
                    miscompares++;
                    $display("FAIL scan_out @%0t: got dig=%b seg=%b nib=%h fd=%b, want dig=%b seg=%b nib=%h fd=%b",
                             $time, got_o.dig, got_o.seg, got_o.nib, got_o.fd,
                             exp_o.dig, exp_o.seg, exp_o.nib, exp_o.fd);
                end
            end
        end
    end

    task automatic chk_ready(input string name);
        vectors++;
        if (value_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL %s @%0t: got ready=%b, want %b", name, $time, value_ready, exp_rdy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
            vectors++;
            if ({dig_en, seg_out, nibble, frame_done, value_ready} !== {4'b0, 7'b0, 4'b0, 2'b01})
            begin
                miscompares++;
                $display("FAIL reset_state @%0t: got dig=%b seg=%b nib=%h fd=%b rdy=%b, want 0/0/0/0/1",
                         $time, dig_en, seg_out, nibble, frame_done, value_ready);
            end
        end
        reset_n   = 1'b1;
        drv_rst_n = 1'b1;
    endtask

    // Frame 0: 12AF accepted at cycle 7 (c=6); 3333 held while pending is full.
    task automatic test_handshake();
        push_frame(16'h0000, 1'b0, 1'b0, 1, FRAME - 1);
        for (int c = 1; c < FRAME; c++) begin
            drv_valid = (c == 6) || (c >= 10);
            drv_value = (c == 6) ? 16'h12AF : 16'h3333;
            tick();
            exp_rdy = (c <= 6);
            chk_ready("ready_frame0");
        end
    endtask

    // Frame 1 shows 12AF and takes 3333 at its first cycle; frame 2 shows 3333.
    task automatic test_back_to_back();
        push_frame(16'h12AF, 1'b0, 1'b1, 0, FRAME - 1);
        for (int c = 0; c < FRAME; c++) begin
            drv_valid = (c == 0);
            drv_value = 16'h3333;
            tick();
            exp_rdy = (c == 0);
            chk_ready("ready_frame1");
        end
        push_frame(16'h3333, 1'b0, 1'b1, 0, FRAME - 1);
        for (int c = 0; c < FRAME; c++) begin
            drv_valid = (c == 3);
            drv_value = 16'h0005;
            tick();
            exp_rdy = (c <= 3);
            chk_ready("ready_frame2");
        end
    endtask

    // 0005 and 0000 under leading-zero blanking; 0000 arrives on the frame-end edge.
    task automatic test_lzb();
        drv_lzb = 1'b1;
        push_frame(16'h0005, 1'b1, 1'b1, 0, FRAME - 1);
        for (int c = 0; c < FRAME; c++) begin
            drv_valid = (c == FRAME - 1);
            drv_value = 16'h0000;
            tick();
            exp_rdy = 1'b1;
            chk_ready("ready_frame3");
        end
        push_frame(16'h0005, 1'b1, 1'b1, 0, FRAME - 1);
        for (int c = 0; c < FRAME; c++) begin
            drv_valid = 1'b0;
            tick();
            exp_rdy = 1'b0;
            chk_ready("ready_frame4");
        end
        push_frame(16'h0000, 1'b1, 1'b1, 0, FRAME - 1);
        for (int c = 0; c < FRAME; c++) begin
            drv_valid = (c == 2);
            drv_value = 16'h12AF;
            tick();
            exp_rdy = (c <= 2);
            chk_ready("ready_frame5");
        end
    endtask

    // Reset during digit 2 SHOW with 3333 pending: both values are lost.
    task automatic test_reset_midframe();
        drv_lzb = 1'b0;
        push_frame(16'h12AF, 1'b0, 1'b1, 0, 12);
        for (int c = 0; c <= 12; c++) begin
            drv_valid = (c == 1);
            drv_value = 16'h3333;
            drv_rst_n = (c != 12);
            tick();
            exp_rdy = (c <= 1);
            chk_ready("ready_pre_reset");
        end
        drv_valid = 1'b0;
        drv_rst_n = 1'b1;
        push_frame(16'h0000, 1'b0, 1'b0, 0, FRAME - 1);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            exp_rdy = 1'b1;
            chk_ready("ready_post_reset");
        end
        push_frame(16'h0000, 1'b0, 1'b1, 0, FRAME - 1);
        for (int c = 0; c < FRAME; c++) begin
            drv_valid = (c == 2);
            drv_value = 16'h12AF;
            tick();
            exp_rdy = (c <= 2);
            chk_ready("ready_r1");
        end
    endtask

    // en low for 7 cycles from the 2nd SHOW cycle of digit 1; capture still works.
    task automatic test_en_pause();
        obs_t p;
        push_frame(16'h12AF, 1'b0, 1'b1, 0, 6);
        p     = model(16'h12AF, 1'b0, 7, 1'b0);
        p.dig = '0;
        p.seg = '0;
        repeat (7) sb_q.push_back(p);
        push_frame(16'h12AF, 1'b0, 1'b1, 7, FRAME - 1);
        for (int k = 0; k < FRAME + 7; k++) begin
            drv_en    = !(k >= 7 && k < 14);
            drv_valid = (k == 8);
            drv_value = 16'h0005;
            tick();
            exp_rdy = (k <= 8);
            chk_ready("ready_pause");
        end
        drv_en    = 1'b1;
        drv_valid = 1'b0;
        push_frame(16'h0005, 1'b0, 1'b1, 0, FRAME - 1);
        push_frame(16'h0005, 1'b0, 1'b1, 0, 0);
        for (int c = 0; c <= FRAME; c++) begin
            tick();
            exp_rdy = 1'b1;
            chk_ready("ready_after_pause");
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_back_to_back();
        test_lzb();
        test_reset_midframe();
        test_en_pause();
        #3;
        mon_on = 1'b0;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
